// File: rtl/key_expand.sv
// AES-128 key schedule: expands keyword into round keys 1..10, one round per enabled cycle.
// Latency: 11 enabled cycles from accepted start to the one-cycle done pulse; subkey_k lands k+1 cycles after accept.
// Backpressure: ena=0 freezes all state (a pending done waits); start is ignored unless the FSM is idle.
module key_expand #(
    parameter int NROUNDS = 10
) (
    input  logic         HCLK,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic [127:0] keyword,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic [127:0] subkey0,
    output logic [127:0] subkey1,
    output logic [127:0] subkey2,
    output logic [127:0] subkey3,
    output logic [127:0] subkey4,
    output logic [127:0] subkey5,
    output logic [127:0] subkey6,
    output logic [127:0] subkey7,
    output logic [127:0] subkey8,
    output logic [127:0] subkey9
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // After the last round is written the counter steps once more; that
    // finishing step is what moves the FSM into DONE one cycle later.
    localparam logic [3:0] LAST_RND = 4'(NROUNDS + 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q;
    state_t         state_d;
    logic [3:0]     rnd_q;
    logic [127:0]   work_q;
    logic           key_valid_q;
    logic [127:0]   sub_q [NROUNDS];

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w3;
    logic [31:0]    sub_w3;
    logic [31:0]    t_word;
    logic [127:0]   next_key;

    // One round of the schedule, purely combinational from the work register.
    always_comb begin
        w0       = work_q[127:96];
        w1       = work_q[95:64];
        w2       = work_q[63:32];
        w3       = work_q[31:0];
        rot_w3   = {w3[23:0], w3[31:24]};
        sub_w3   = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                    SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};
        t_word   = sub_w3 ^ {rcon(rnd_q), 24'h000000};
        next_key[127:96] = w0 ^ t_word;
        next_key[95:64]  = w1 ^ next_key[127:96];
        next_key[63:32]  = w2 ^ next_key[95:64];
        next_key[31:0]   = w3 ^ next_key[63:32];
    end

    // Next-state selection; DONE always lasts a single enabled cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXPAND;
            EXPAND:  if (rnd_q == LAST_RND) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, round counter, work key and round-key bank; everything holds while ena is low.
    always_ff @(posedge HCLK) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            work_q      <= '0;
            key_valid_q <= 1'b0;
            for (int i = 0; i < NROUNDS; i++) begin
                sub_q[i] <= '0;
            end
        end else if (ena) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q      <= keyword;
                        rnd_q       <= 4'd1;
                        key_valid_q <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (rnd_q == LAST_RND) begin
                        rnd_q       <= 4'd0;
                        key_valid_q <= 1'b1;
                    end else begin
                        work_q <= next_key;
                        rnd_q  <= rnd_q + 4'd1;
                        for (int i = 0; i < NROUNDS; i++) begin
                            if (rnd_q == 4'(i + 1)) begin
                                sub_q[i] <= next_key;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == EXPAND);
    assign done      = (state_q == DONE);
    assign key_valid = key_valid_q;

    assign subkey0 = sub_q[0];
    assign subkey1 = sub_q[1];
    assign subkey2 = sub_q[2];
    assign subkey3 = sub_q[3];
    assign subkey4 = sub_q[4];
    assign subkey5 = sub_q[5];
    assign subkey6 = sub_q[6];
    assign subkey7 = sub_q[7];
    assign subkey8 = sub_q[8];
    assign subkey9 = sub_q[9];

endmodule
